// File: rtl/chip_burst_sequencer.sv
// Burst front end for the Chip DRAM model: one read/write burst at a time, open-row
// tracking per bank, precharge/activate sequencing and wrap-around column beats.
module chip_burst_sequencer #(
  parameter int BGWIDTH      = 2,
  parameter int BAWIDTH      = 2,
  parameter int COLWIDTH     = 10,
  parameter int CHWIDTH      = 5,
  parameter int DEVICE_WIDTH = 4,
  parameter int BL           = 8,
  parameter int TRP          = 2,
  parameter int TRCD         = 2,
  parameter int TCL          = 2,
  localparam int BANKGROUPS    = 2 ** BGWIDTH,
  localparam int BANKSPERGROUP = 2 ** BAWIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_wr,
  input  logic [BGWIDTH-1:0]          cmd_bg,
  input  logic [BAWIDTH-1:0]          cmd_ba,
  input  logic [CHWIDTH-1:0]          cmd_row,
  input  logic [COLWIDTH-1:0]         cmd_col,
  input  logic [DEVICE_WIDTH*BL-1:0]  wdata,
  output logic [DEVICE_WIDTH*BL-1:0]  rdata,
  output logic                        rdata_valid,
  output logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0]                    rd_o_wr,
  output logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0][DEVICE_WIDTH-1:0]  dqin,
  output logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0][CHWIDTH-1:0]       row,
  output logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0][COLWIDTH-1:0]      column,
  input  logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0][DEVICE_WIDTH-1:0]  dqout,
  output logic [2:0]                  fsm_state
);

  localparam int LB    = $clog2(BL);
  localparam int BW    = BGWIDTH + BAWIDTH;
  localparam int NB    = 2 ** BW;
  localparam int MAXA  = (BL > TRP) ? BL : TRP;
  localparam int MAXB  = (MAXA > TRCD) ? MAXA : TRCD;
  localparam int MAXT  = (MAXB > TCL) ? MAXB : TCL;
  localparam int CW    = $clog2(MAXT) + 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRE      = 3'd1,
    ACT      = 3'd2,
    WR       = 3'd3,
    RD       = 3'd4,
    RD_DRAIN = 3'd5
  } state_t;

  state_t                             state;
  logic [CW-1:0]                      cnt;
  logic                               wr_q;
  logic [BGWIDTH-1:0]                 bg_q;
  logic [BAWIDTH-1:0]                 ba_q;
  logic [CHWIDTH-1:0]                 row_q;
  logic [COLWIDTH-1:0]                col_q;
  logic [DEVICE_WIDTH*BL-1:0]         wdata_q;
  logic [NB-1:0]                      tab_valid;
  logic [NB-1:0][CHWIDTH-1:0]         tab_row;
  logic [TCL:1]                       rd_pipe;
  logic [LB-1:0]                      samp_cnt;

  logic [BW-1:0]  idx_in;
  logic [BW-1:0]  idx_q;
  logic           hit;
  logic [LB-1:0]  beat;
  logic [LB-1:0]  col_lo;

  assign idx_in    = {cmd_bg, cmd_ba};
  assign idx_q     = {bg_q, ba_q};
  assign hit       = tab_valid[idx_in] && (tab_row[idx_in] == cmd_row);
  assign beat      = cnt[LB-1:0];
  assign col_lo    = col_q[LB-1:0] + beat;
  assign fsm_state = state;

  // Handshake: a command transfers on the rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high exactly while the FSM sits in IDLE, and the command fields are
  // captured on that edge so the requester may change them afterwards.
  assign cmd_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      wr_q        <= 1'b0;
      bg_q        <= '0;
      ba_q        <= '0;
      row_q       <= '0;
      col_q       <= '0;
      wdata_q     <= '0;
      tab_valid   <= '0;
      tab_row     <= '0;
      rd_pipe     <= '0;
      samp_cnt    <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      // rd_pipe[i] is set when a read beat was driven i cycles ago.
      rd_pipe[1] <= (state == RD);
      for (int i = 2; i <= TCL; i++) rd_pipe[i] <= rd_pipe[i-1];
      if (rd_pipe[TCL]) begin
        rdata[samp_cnt*DEVICE_WIDTH +: DEVICE_WIDTH] <= dqout[bg_q][ba_q];
        samp_cnt <= samp_cnt + LB'(1);
        if (samp_cnt == LB'(BL - 1)) rdata_valid <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (cmd_valid) begin
            wr_q    <= cmd_wr;
            bg_q    <= cmd_bg;
            ba_q    <= cmd_ba;
            row_q   <= cmd_row;
            col_q   <= cmd_col;
            wdata_q <= wdata;
            cnt     <= '0;
            if (hit) begin
              state <= cmd_wr ? WR : RD;
            end else if (tab_valid[idx_in]) begin
              state             <= PRE;
              tab_valid[idx_in] <= 1'b0;
            end else begin
              state <= ACT;
            end
          end
        end
        PRE: begin
          if (cnt == CW'(TRP - 1)) begin
            cnt   <= '0;
            state <= ACT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ACT: begin
          if (cnt == CW'(TRCD - 1)) begin
            cnt              <= '0;
            tab_valid[idx_q] <= 1'b1;
            tab_row[idx_q]   <= row_q;
            state            <= wr_q ? WR : RD;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WR, RD: begin
          if (cnt == CW'(BL - 1)) begin
            cnt   <= '0;
            state <= (state == WR) ? IDLE : RD_DRAIN;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RD_DRAIN: begin
          if (cnt == CW'(TCL - 1)) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Only the target bank is driven, and only during beats; data follows burst order.
  always_comb begin
    rd_o_wr = '0;
    dqin    = '0;
    row     = '0;
    column  = '0;
    if (state == WR || state == RD) begin
      rd_o_wr[bg_q][ba_q] = (state == WR);
      row[bg_q][ba_q]     = row_q;
      column[bg_q][ba_q]  = {col_q[COLWIDTH-1:LB], col_lo};
      if (state == WR) dqin[bg_q][ba_q] = wdata_q[beat*DEVICE_WIDTH +: DEVICE_WIDTH];
    end
  end

endmodule

// File: tb/tb_chip_burst_sequencer.sv
// Directed bench for chip_burst_sequencer with a small behavioural Chip memory model
// (fixed read latency of two cycles) attached to the per-bank arrays.
module tb_chip_burst_sequencer;

  logic clk;
  logic rst_n;
  logic cmd_valid;
  logic cmd_ready;
  logic cmd_wr;
  logic [1:0] cmd_bg;
  logic [1:0] cmd_ba;
  logic [4:0] cmd_row;
  logic [9:0] cmd_col;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic rdata_valid;
  logic [3:0][3:0] rd_o_wr;
  logic [3:0][3:0][3:0] dqin;
  logic [3:0][3:0][4:0] row;
  logic [3:0][3:0][9:0] column;
  logic [3:0][3:0][3:0] dqout;
  logic [2:0] fsm_state;

  int n_checks = 0;
  int n_errors = 0;

  // Per-cycle observations of the last command, cycle 1 = first cycle after accept.
  logic [19:0] obs_tgt [1:40];
  logic        obs_quiet [1:40];
  logic        obs_rv [1:40];
  logic [31:0] obs_rdata [1:40];
  int          ready_cyc;

  chip_burst_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_bg(cmd_bg), .cmd_ba(cmd_ba), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .wdata(wdata), .rdata(rdata), .rdata_valid(rdata_valid),
    .rd_o_wr(rd_o_wr), .dqin(dqin), .row(row), .column(column), .dqout(dqout),
    .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- Chip model ----------------
  logic [3:0] mem [int];
  logic [3:0][3:0][3:0] dq_s1;
  logic [3:0][3:0][3:0] dq_s2;
  assign dqout = dq_s2;

  always @(posedge clk) begin
    for (int g = 0; g < 4; g++) begin
      for (int b = 0; b < 4; b++) begin
        int key;
        key = (g << 17) | (b << 15) | (int'(row[g][b]) << 10) | int'(column[g][b]);
        dq_s1[g][b] <= mem.exists(key) ? mem[key] : 4'h0;
        if (rd_o_wr[g][b]) mem[key] = dqin[g][b];
      end
    end
    dq_s2 <= dq_s1;
  end

  // ---------------- model of the expected target-bank signals ----------------
  function automatic logic [19:0] exp_tgt(input int c, input int first, input logic wr,
                                          input logic [4:0] r, input logic [9:0] col0,
                                          input logic [31:0] wd);
    int k;
    logic [2:0] lo;
    logic [3:0] dq;
    k = c - first;
    if (k < 0 || k >= 8) return 20'h0;
    lo = col0[2:0] + 3'(k);
    dq = wr ? wd[k*4 +: 4] : 4'h0;
    return {wr, r, col0[9:3], lo, dq};
  endfunction

  // ---------------- driver ----------------
  task automatic do_cmd(input logic wr, input logic [1:0] bg, input logic [1:0] ba,
                        input logic [4:0] r, input logic [9:0] c, input logic [31:0] wd);
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_bg    = bg;
    cmd_ba    = ba;
    cmd_row   = r;
    cmd_col   = c;
    wdata     = wd;
    @(posedge clk);
    ready_cyc = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        cmd_valid = 1'b0;
        cmd_wr    = ~wr;
        cmd_row   = 5'($urandom_range(0, 31));
        cmd_col   = 10'($urandom_range(0, 1023));
        wdata     = $urandom;
      end
      obs_tgt[cyc]   = {rd_o_wr[bg][ba], row[bg][ba], column[bg][ba], dqin[bg][ba]};
      obs_quiet[cyc] = 1'b1;
      for (int g = 0; g < 4; g++)
        for (int b = 0; b < 4; b++)
          if ((g != int'(bg) || b != int'(ba)) &&
              (rd_o_wr[g][b] || row[g][b] != 0 || column[g][b] != 0 || dqin[g][b] != 0))
            obs_quiet[cyc] = 1'b0;
      obs_rv[cyc]    = rdata_valid;
      obs_rdata[cyc] = rdata;
      if (cmd_ready) begin
        ready_cyc = cyc;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_bg = '0; cmd_ba = '0;
    cmd_row = '0; cmd_col = '0; wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (rd_o_wr !== '0 || dqin !== '0 || row !== '0 || column !== '0) begin
      n_errors++;
      $display("FAIL reset_chip_arrays: rd_o_wr=%h dqin=%h row=%h column=%h, expected all 0",
               rd_o_wr, dqin, row, column);
    end
    n_checks++;
    if (rdata !== 32'h0 || rdata_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_rdata: rdata=%h rdata_valid=%b, expected 0/0", rdata, rdata_valid);
    end
    n_checks++;
    if (cmd_ready !== 1'b1 || fsm_state !== 3'd0) begin
      n_errors++;
      $display("FAIL reset_idle: cmd_ready=%b state=%0d, expected 1/0", cmd_ready, fsm_state);
    end
  endtask

  task automatic test_write_closed();
    do_cmd(1'b1, 2'd1, 2'd1, 5'd1, 10'd0, 32'h87654321);
    n_checks++;
    if (ready_cyc !== 11) begin
      n_errors++;
      $display("FAIL write_closed_ready: cmd_ready at cycle %0d, expected 11", ready_cyc);
    end
    for (int c = 1; c <= ready_cyc; c++) begin
      n_checks++;
      if (obs_tgt[c] !== exp_tgt(c, 3, 1'b1, 5'd1, 10'd0, 32'h87654321) ||
          obs_quiet[c] !== 1'b1 || obs_rv[c] !== 1'b0) begin
        n_errors++;
        $display("FAIL write_closed_cycle%0d: tgt=%h quiet=%b rv=%b, expected tgt=%h quiet=1 rv=0",
                 c, obs_tgt[c], obs_quiet[c], obs_rv[c],
                 exp_tgt(c, 3, 1'b1, 5'd1, 10'd0, 32'h87654321));
      end
    end
  endtask

  task automatic test_back_to_back_read_hit();
    do_cmd(1'b0, 2'd1, 2'd1, 5'd1, 10'd0, 32'h0);
    n_checks++;
    if (ready_cyc !== 11 || obs_rdata[11] !== 32'h87654321) begin
      n_errors++;
      $display("FAIL read_hit_data: ready at %0d rdata=%h, expected 11 / 87654321",
               ready_cyc, obs_rdata[11]);
    end
    for (int c = 1; c <= ready_cyc; c++) begin
      n_checks++;
      if (obs_tgt[c] !== exp_tgt(c, 1, 1'b0, 5'd1, 10'd0, 32'h0) ||
          obs_quiet[c] !== 1'b1 || obs_rv[c] !== (c == 11)) begin
        n_errors++;
        $display("FAIL read_hit_cycle%0d: tgt=%h quiet=%b rv=%b, expected tgt=%h quiet=1 rv=%b",
                 c, obs_tgt[c], obs_quiet[c], obs_rv[c],
                 exp_tgt(c, 1, 1'b0, 5'd1, 10'd0, 32'h0), c == 11);
      end
    end
  endtask

  task automatic test_wrap();
    do_cmd(1'b1, 2'd2, 2'd0, 5'd3, 10'd13, 32'hA5C3F019);
    n_checks++;
    if (ready_cyc !== 11) begin
      n_errors++;
      $display("FAIL wrap_write_ready: cmd_ready at cycle %0d, expected 11", ready_cyc);
    end
    for (int c = 1; c <= ready_cyc; c++) begin
      n_checks++;
      if (obs_tgt[c] !== exp_tgt(c, 3, 1'b1, 5'd3, 10'd13, 32'hA5C3F019) || obs_quiet[c] !== 1'b1) begin
        n_errors++;
        $display("FAIL wrap_write_cycle%0d: tgt=%h quiet=%b, expected tgt=%h quiet=1",
                 c, obs_tgt[c], obs_quiet[c], exp_tgt(c, 3, 1'b1, 5'd3, 10'd13, 32'hA5C3F019));
      end
    end
    do_cmd(1'b0, 2'd2, 2'd0, 5'd3, 10'd8, 32'h0);
    n_checks++;
    if (ready_cyc !== 11 || obs_rv[11] !== 1'b1 || obs_rdata[11] !== 32'h019A5C3F) begin
      n_errors++;
      $display("FAIL wrap_read_data: ready at %0d rv=%b rdata=%h, expected 11 / 1 / 019a5c3f",
               ready_cyc, obs_rv[11], obs_rdata[11]);
    end
    for (int c = 1; c <= ready_cyc; c++) begin
      n_checks++;
      if (obs_tgt[c] !== exp_tgt(c, 1, 1'b0, 5'd3, 10'd8, 32'h0)) begin
        n_errors++;
        $display("FAIL wrap_read_cycle%0d: tgt=%h, expected %h",
                 c, obs_tgt[c], exp_tgt(c, 1, 1'b0, 5'd3, 10'd8, 32'h0));
      end
    end
  endtask

  task automatic test_row_miss();
    do_cmd(1'b0, 2'd1, 2'd1, 5'd2, 10'd0, 32'h0);
    n_checks++;
    if (ready_cyc !== 15 || obs_rv[15] !== 1'b1 || obs_rdata[15] !== 32'h0) begin
      n_errors++;
      $display("FAIL row_miss_read: ready at %0d rv=%b rdata=%h, expected 15 / 1 / 00000000",
               ready_cyc, obs_rv[15], obs_rdata[15]);
    end
    n_checks++;
    if (obs_rdata[5] !== 32'h019A5C3F) begin
      n_errors++;
      $display("FAIL rdata_hold: rdata=%h before first sample, expected 019a5c3f", obs_rdata[5]);
    end
    for (int c = 1; c <= ready_cyc; c++) begin
      n_checks++;
      if (obs_tgt[c] !== exp_tgt(c, 5, 1'b0, 5'd2, 10'd0, 32'h0) ||
          obs_quiet[c] !== 1'b1 || obs_rv[c] !== (c == 15)) begin
        n_errors++;
        $display("FAIL row_miss_cycle%0d: tgt=%h quiet=%b rv=%b, expected tgt=%h quiet=1 rv=%b",
                 c, obs_tgt[c], obs_quiet[c], obs_rv[c],
                 exp_tgt(c, 5, 1'b0, 5'd2, 10'd0, 32'h0), c == 15);
      end
    end
    do_cmd(1'b1, 2'd1, 2'd1, 5'd2, 10'd4, 32'h13572468);
    n_checks++;
    if (ready_cyc !== 9) begin
      n_errors++;
      $display("FAIL row2_write_hit_ready: cmd_ready at cycle %0d, expected 9", ready_cyc);
    end
    for (int c = 1; c <= ready_cyc; c++) begin
      n_checks++;
      if (obs_tgt[c] !== exp_tgt(c, 1, 1'b1, 5'd2, 10'd4, 32'h13572468)) begin
        n_errors++;
        $display("FAIL row2_write_cycle%0d: tgt=%h, expected %h",
                 c, obs_tgt[c], exp_tgt(c, 1, 1'b1, 5'd2, 10'd4, 32'h13572468));
      end
    end
    do_cmd(1'b0, 2'd1, 2'd1, 5'd2, 10'd4, 32'h0);
    n_checks++;
    if (ready_cyc !== 11 || obs_rv[11] !== 1'b1 || obs_rdata[11] !== 32'h13572468) begin
      n_errors++;
      $display("FAIL row2_read_hit: ready at %0d rv=%b rdata=%h, expected 11 / 1 / 13572468",
               ready_cyc, obs_rv[11], obs_rdata[11]);
    end
  endtask

  task automatic test_abort();
    logic rv_seen;
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_bg = 2'd1; cmd_ba = 2'd1;
    cmd_row = 5'd2; cmd_col = 10'd0; wdata = '0;
    @(posedge clk);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) cmd_valid = 1'b0;
    end
    n_checks++;
    if (rd_o_wr[1][1] !== 1'b0 || row[1][1] !== 5'd2 || column[1][1] !== 10'd3) begin
      n_errors++;
      $display("FAIL abort_beat3: rd_o_wr=%b row=%0d column=%0d, expected 0/2/3",
               rd_o_wr[1][1], row[1][1], column[1][1]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (rd_o_wr !== '0 || dqin !== '0 || row !== '0 || column !== '0 ||
        rdata_valid !== 1'b0 || rdata !== 32'h0 || cmd_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL abort_outputs: rd_o_wr=%h row=%h column=%h rv=%b rdata=%h ready=%b, expected zeros and ready=1",
               rd_o_wr, row, column, rdata_valid, rdata, cmd_ready);
    end
    rv_seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      rv_seen |= rdata_valid;
    end
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      rv_seen |= rdata_valid;
    end
    n_checks++;
    if (rv_seen !== 1'b0 || cmd_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL abort_no_pulse: rdata_valid seen=%b cmd_ready=%b, expected 0/1", rv_seen, cmd_ready);
    end
    do_cmd(1'b0, 2'd1, 2'd1, 5'd2, 10'd0, 32'h0);
    n_checks++;
    if (ready_cyc !== 13 || obs_rv[13] !== 1'b1 || obs_rdata[13] !== 32'h24681357) begin
      n_errors++;
      $display("FAIL abort_reactivate: ready at %0d rv=%b rdata=%h, expected 13 / 1 / 24681357",
               ready_cyc, obs_rv[13], obs_rdata[13]);
    end
    for (int c = 1; c <= ready_cyc; c++) begin
      n_checks++;
      if (obs_tgt[c] !== exp_tgt(c, 3, 1'b0, 5'd2, 10'd0, 32'h0)) begin
        n_errors++;
        $display("FAIL abort_reactivate_cycle%0d: tgt=%h, expected %h",
                 c, obs_tgt[c], exp_tgt(c, 3, 1'b0, 5'd2, 10'd0, 32'h0));
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_write_closed();
    test_back_to_back_read_hit();
    test_wrap();
    test_row_miss();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/chip_burst_sequencer.md
# chip_burst_sequencer

Burst-level front end for the `Chip` DRAM model. It accepts one read or write burst command at a time over a valid/ready handshake and tracks the open row of every bank. Each command runs the required precharge/activate sequence, then drives the Chip's per-bank `rd_o_wr`/`dqin`/`row`/`column` arrays beat by beat with wrap-around column ordering. Read beats from `dqout` are collected into one burst-wide word. It sits between the memory-controller model and `Chip`, replacing hand-driven per-beat stimulus.

## Interface
- BGWIDTH, 2, bank-group address width; BANKGROUPS = 2**BGWIDTH
- BAWIDTH, 2, bank address width; BANKSPERGROUP = 2**BAWIDTH
- COLWIDTH, 10, column address width
- CHWIDTH, 5, row address width
- DEVICE_WIDTH, 4, data bits per beat
- BL, 8, burst length; power of two, at least 2
- TRP, 2, precharge cycles; at least 1
- TRCD, 2, activate-to-column cycles; at least 1
- TCL, 2, cycles from a read column being driven to its `dqout` sample; at least 1

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_wr  in  1  1 = write, 0 = read
- cmd_bg  in  BGWIDTH  target bank group
- cmd_ba  in  BAWIDTH  target bank
- cmd_row  in  CHWIDTH  target row
- cmd_col  in  COLWIDTH  starting column
- wdata  in  DEVICE_WIDTH*BL  write burst; beat k is `[k*DEVICE_WIDTH +: DEVICE_WIDTH]`
- rdata  out  DEVICE_WIDTH*BL  assembled read burst, same beat packing
- rdata_valid  out  1  one-cycle pulse when `rdata` is complete
- rd_o_wr  out  1 per bank, [BANKGROUPS-1:0][BANKSPERGROUP-1:0]  to Chip
- dqin  out  DEVICE_WIDTH per bank, same array  to Chip
- row  out  CHWIDTH per bank, same array  to Chip
- column  out  COLWIDTH per bank, same array  to Chip
- dqout  in  DEVICE_WIDTH per bank, same array  from Chip

## Operation
- **Accept.** A command is accepted on `cmd_valid && cmd_ready`. All `cmd_*` fields and `wdata` are registered at accept and are don't-care afterwards.
- **Open-row table.** One valid bit and one row register per bank. All entries are cleared by reset.
- **Next state from IDLE, per target bank:**
  - entry valid and rows equal (hit): go to the burst state.
  - entry valid and rows differ (miss, bank open): go to PRE.
  - entry invalid (miss, bank closed): go to ACT.
- **FSM states:**
  - IDLE.
  - PRE: TRP cycles; clears the table entry.
  - ACT: TRCD cycles; sets the entry to the new row on exit.
  - WR: BL cycles.
  - RD: BL cycles.
  - RD_DRAIN: TCL cycles.
  - WR and RD_DRAIN return to IDLE. RD goes to RD_DRAIN.
- **Column wrap.** Beat k drives `column = {cmd_col[COLWIDTH-1:log2(BL)], (cmd_col[log2(BL)-1:0] + k) mod BL}`. Upper column bits never change within a burst.
- **WR beats** drive the target bank only:
  - `rd_o_wr = 1`
  - `row` = registered row
  - `column` = wrapped column
  - `dqin` = `wdata` beat k, indexed by burst order and not by column
- **RD beats:** `rd_o_wr = 0`, with `row` and `column` driven as for WR. The target bank's `dqout` is sampled TCL cycles after each beat is driven and stored in `rdata` beat k. `rdata_valid` pulses on the cycle after the last sample.
- **Quiet banks.** Every non-target bank, and the target bank outside WR/RD, drives 0 on `rd_o_wr`, `row`, `column` and `dqin`.
- **Hold.** `rdata` holds its value until the next read's first sample overwrites beat 0.
- **Counters** are sized by `$clog2` of the largest of BL, TRP, TRCD and TCL, plus 1. No overflow is possible.

## Timing
- **Reset values:** every output is 0, except `cmd_ready` = 1. FSM is in IDLE.
- **Reset mid-operation:** the burst is aborted immediately (asynchronously). Chip-facing outputs go to 0. No `rdata_valid` pulse. The table is cleared.
- **Timeline** (accept at cycle 0; P = TRP on a miss with the bank open, else 0; A = TRCD on any miss, else 0):
  - first beat at cycle 1+P+A.
  - last beat at cycle P+A+BL.
- **Write:** `cmd_ready` rises at cycle P+A+BL+1.
- **Read:**
  - `rdata_valid` pulses at cycle P+A+BL+TCL+1.
  - `cmd_ready` rises in the same cycle as `rdata_valid`.
- **Back-to-back:** a command offered while `cmd_ready` = 1 is accepted in that same cycle. There are no bubbles beyond those listed above.

## Test plan
- **Reset:** hold `rst_n` low for 3 cycles, then release → all Chip-facing arrays are 0, `rdata` = 0, `cmd_ready` = 1.
- **Write, closed bank:** write bg=1, ba=1, row=1, col=0, `wdata` = 0x87654321 → `rd_o_wr[1][1]` = 1 for cycles 3–10 (TRCD = 2) with `column` 0..7 and `dqin` 1,2,…,8; all other banks 0; `cmd_ready` returns at cycle 11.
- **Read hit, real Chip attached:** read bg=1, ba=1, row=1, col=0 right after the write → no ACT, beats at cycles 1–8, `rdata` = 0x87654321 with `rdata_valid` at cycle 11.
- **Wrap-around:** write col=13 → columns 13,14,15,8,9,10,11,12; a read at col=8 returns beats reordered to match.
- **Row miss, bank open:** read bg=1, ba=1, row=2 after row 1 is open → first beat at cycle 5 (TRP + TRCD = 4); the table then holds row 2, and a following row-2 read is a hit.
- **Abort:** drop `rst_n` during beat 3 of a read → outputs 0 immediately, no `rdata_valid`, `cmd_ready` = 1 after release, and the next command to that bank takes the ACT path.
